// File: rtl/pio_in_edge_irq.sv
// ============================================================================
// pio_in_edge_irq
// ----------------------------------------------------------------------------
// Parametrised Avalon-MM input PIO. A WIDTH-bit asynchronous input bus is
// synchronised into clk, optionally debounced, and edge-detected per bit into
// a sticky edge-capture register that drives a maskable level interrupt.
//
// Optional feature macro: PIO_IN_DEBOUNCE_EN
//   defined   -> tick-sampled two-sample debounce filter between the
//                synchroniser and the edge detector
//   undefined -> debounced value is the synchroniser output
//
// Register map (word address):
//   0 DATA          read-only, debounced input value
//   1 IRQ_MASK      read/write
//   2 EDGE_CAPTURE  read, write-1-to-clear
//   3 RAW           read-only, synchroniser output (undebounced)
//
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   address     register select
//   chipselect  slave select
//   read        read strobe (qualified by chipselect)
//   write_n     active-low write strobe (qualified by chipselect)
//   writedata   write data
//   readdata    registered read data, 1-cycle latency
//   in_port     asynchronous input bus
//   irq         level interrupt, active high
// ============================================================================
module pio_in_edge_irq #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // ------------------------------------------------------------------
    // Synchroniser chain
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync_in;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (reset) r_sync[gi] <= '0;
                else       r_sync[gi] <= in_port;
            end
        end else begin : g_rest
            always_ff @(posedge clk) begin
                if (reset) r_sync[gi] <= '0;
                else       r_sync[gi] <= r_sync[gi-1];
            end
        end
    end

    assign w_sync_in = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_deb;

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] r_tick_cnt;
    logic [WIDTH-1:0] r_samp;
    logic [WIDTH-1:0] r_deb;
    logic             w_tick;
    logic [WIDTH-1:0] w_stable;

    assign w_tick   = (r_tick_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    // A bit is accepted only when two consecutive tick samples agree.
    assign w_stable = ~(w_sync_in ^ r_samp);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_samp     <= '0;
            r_deb      <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            if (w_tick) begin
                r_samp <= w_sync_in;
                r_deb  <= (r_deb & ~w_stable) | (w_sync_in & w_stable);
            end
        end
    end

    assign w_deb = r_deb;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign w_deb = w_sync_in;
`endif

    // ------------------------------------------------------------------
    // Edge detect
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_edge;

    if (EDGE_TYPE == 0) begin : g_rise
        assign w_edge = w_deb & ~r_prev;
    end else if (EDGE_TYPE == 1) begin : g_fall
        assign w_edge = ~w_deb & r_prev;
    end else begin : g_any
        assign w_edge = w_deb ^ r_prev;
    end

    // ------------------------------------------------------------------
    // Bus interface and registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [31:0]      r_readdata;
    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    assign w_wr  = chipselect & ~write_n;
    assign w_rd  = chipselect & read;
    assign w_clr = (w_wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

    // Upper writedata bits are ignored when WIDTH < 32.
    assign w_unused = ^writedata;

    // Read mux sees pre-write register values, so a simultaneous
    // read and write of the same register returns the old contents.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux = 32'(w_deb);
            2'd1:    w_rd_mux = 32'(r_mask);
            2'd2:    w_rd_mux = 32'(r_cap);
            default: w_rd_mux = 32'(w_sync_in);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_mask     <= '0;
            r_cap      <= '0;
            r_readdata <= '0;
        end else begin
            r_prev <= w_deb;
            // Clear first, then OR in new edges: set wins on collision.
            r_cap  <= (r_cap & ~w_clr) | w_edge;
            if (w_wr && address == 2'd1)
                r_mask <= writedata[WIDTH-1:0];
            if (w_rd)
                r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_cap & r_mask);

endmodule
